// File: rtl/uart_rx_engine.sv
`timescale 1ns/1ps
// uart_rx_engine: UART receiver. Oversamples the serial line, rebuilds 7/8-bit
// frames with optional parity, and holds the byte and status until read.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority vote per bit).
module uart_rx_engine #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic [3:0] baud,
    input  logic       read_strobe,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    localparam int unsigned CNT_W = 18;
    localparam int unsigned BIT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_e;

    // Bit time in clocks for each rate select; out-of-range selects use the fastest rate.
    function automatic logic [CNT_W-1:0] bit_time(input logic [3:0] sel);
        case (sel)
            4'd0:    return 18'd166667;
            4'd1:    return 18'd41667;
            4'd2:    return 18'd20833;
            4'd3:    return 18'd10417;
            4'd4:    return 18'd5208;
            4'd5:    return 18'd2604;
            4'd6:    return 18'd1302;
            4'd7:    return 18'd868;
            4'd8:    return 18'd434;
            4'd9:    return 18'd217;
            4'd10:   return 18'd109;
            default: return 18'd54;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    state_e                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [BIT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [7:0]             shreg_q,  shreg_d;
    logic                   par_q,    par_d;
    logic                   stop_q,   stop_d;
    logic                   eight_q,  eight_d;
    logic                   pen_q,    pen_d;
    logic                   ohel_q,   ohel_d;
    logic [3:0]             baud_q,   baud_d;
    logic [7:0]             rx_data_q,  rx_data_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   perr_q,     perr_d;
    logic                   ferr_q,     ferr_d;
    logic                   ovf_q,      ovf_d;

    logic                   rx_s_c;
    logic                   fall_c;
    logic                   samp_c;
    logic [CNT_W-1:0]       k_c;
    logic [CNT_W-1:0]       half_load_c;
    logic [BIT_W-1:0]       last_bit_c;
    logic [7:0]             byte_c;

    assign rx_s_c = sync_q[SYNC_STAGES-1];
    assign fall_c = rx_prev_q & ~rx_s_c;

`ifdef UART_RX_MAJORITY_EN
    // Vote over the line one clock before, at, and one clock after the nominal point;
    // the earlier synchronizer stage supplies the look-ahead so latency is unchanged.
    logic rx_next_c;
    assign rx_next_c = sync_q[SYNC_STAGES-2];
    assign samp_c    = (rx_prev_q & rx_s_c) | (rx_prev_q & rx_next_c) | (rx_s_c & rx_next_c);
`else
    assign samp_c = rx_s_c;
`endif

    // The edge is seen one clock after it leaves the synchronizer, so the first wait is H-2.
    assign k_c         = bit_time(baud_q);
    assign half_load_c = (bit_time(baud) >> 1) - CNT_W'(2);
    assign last_bit_c  = eight_q ? BIT_W'(7) : BIT_W'(6);
    assign byte_c      = eight_q ? shreg_q : {1'b0, shreg_q[7:1]};

    assign rx_data  = rx_data_q;
    assign rx_ready = rx_ready_q;
    assign perr     = perr_q;
    assign ferr     = ferr_q;
    assign ovf      = ovf_q;

    // Input synchronizer and previous-sample register for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev_q <= rx_s_c;
        end
    end

    // Frame state, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            stop_q     <= 1'b1;
            eight_q    <= 1'b1;
            pen_q      <= 1'b0;
            ohel_q     <= 1'b0;
            baud_q     <= '0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            stop_q     <= stop_d;
            eight_q    <= eight_d;
            pen_q      <= pen_d;
            ohel_q     <= ohel_d;
            baud_q     <= baud_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state, bit sampling and status update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        stop_d     = stop_q;
        eight_d    = eight_q;
        pen_d      = pen_q;
        ohel_d     = ohel_q;
        baud_d     = baud_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = rx_ready_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovf_d      = ovf_q;

        if (read_strobe && rx_ready_q) begin
            rx_ready_d = 1'b0;
            ovf_d      = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (fall_c) begin
                    eight_d = eight;
                    pen_d   = pen;
                    ohel_d  = ohel;
                    baud_d  = baud;
                    cnt_d   = half_load_c;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (samp_c) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d    = k_c - CNT_W'(1);
                        bitcnt_d = '0;
                        state_d  = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d = {samp_c, shreg_q[7:1]};
                    cnt_d   = k_c - CNT_W'(1);
                    if (bitcnt_q == last_bit_c) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == '0) begin
                    par_d   = samp_c;
                    cnt_d   = k_c - CNT_W'(1);
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    stop_d  = samp_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                rx_data_d  = byte_c;
                perr_d     = pen_q & (((^byte_c) ^ par_q) != ohel_q);
                ferr_d     = ~stop_q;
                rx_ready_d = 1'b1;
                if (rx_ready_q && !read_strobe) begin
                    ovf_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for uart_rx_engine with a frame-level reference model.
module tb_uart_rx_engine;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic [3:0] baud;
    logic       read_strobe;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       perr;
    logic       ferr;
    logic       ovf;

    uart_rx_engine #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .rx          (rx),
        .eight       (eight),
        .pen         (pen),
        .ohel        (ohel),
        .baud        (baud),
        .read_strobe (read_strobe),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .perr        (perr),
        .ferr        (ferr),
        .ovf         (ovf)
    );

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
        logic       was_low;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_pass;
    int   n_total;
    logic ready_prev_s;

    // Reference model of the processor-visible registers.
    logic [7:0] m_data;
    logic       m_ready, m_perr, m_ferr, m_ovf;

    int KTAB[12] = '{166667, 41667, 20833, 10417, 5208, 2604, 1302, 868, 434, 217, 109, 54};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ktime(input logic [3:0] b);
        return KTAB[(b > 4'd11) ? 11 : int'(b)];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_rx_data"},  rx_data,  m_data);
        chk({tag, "_rx_ready"}, rx_ready, m_ready);
        chk({tag, "_perr"},     perr,     m_perr);
        chk({tag, "_ferr"},     ferr,     m_ferr);
        chk({tag, "_ovf"},      ovf,      m_ovf);
    endtask

    // Monitor: compare the expected record when its completion cycle arrives.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("frame_rx_data",  rx_data,  e.data);
                chk("frame_rx_ready", rx_ready, 1);
                chk("frame_perr",     perr,     e.perr);
                chk("frame_ferr",     ferr,     e.ferr);
                chk("frame_ovf",      ovf,      e.ovf);
                if (e.was_low) chk("ready_rise_time", ready_prev_s, 0);
            end else if (rx_ready && !ready_prev_s) begin
                n_total++;
                $display("FAIL unexpected_ready: rx_ready rose at cycle %0d, required no frame completion", cyc);
            end
        end
        ready_prev_s <= rx_ready;
    end

    // Drive one frame on rx and push what the processor port should show on completion.
    task automatic send_frame(input logic [7:0] d, input logic e8, input logic p_en,
                              input logic odd, input logic [3:0] b, input logic par_flip,
                              input logic stop_low, input logic strobe_done,
                              input logic scramble, input int spike_bit);
        int k, h, nb, c, nd;
        logic [7:0] dd;
        exp_t e;
        k  = ktime(b);
        h  = k / 2;
        nd = e8 ? 8 : 7;
        nb = nd + (p_en ? 1 : 0) + 1;
        dd = e8 ? d : {1'b0, d[6:0]};
        eight = e8; pen = p_en; ohel = odd; baud = b;
        hold(1);
        rx = 1'b0;
        c  = cyc;
        e.due     = c + 2 + h + k * nb + 1;
        e.data    = dd;
        e.perr    = p_en & par_flip;
        e.ferr    = stop_low;
        e.ovf     = strobe_done ? 1'b0 : m_ready;
        e.was_low = !m_ready;
        q.push_back(e);
        m_data = dd; m_perr = e.perr; m_ferr = e.ferr; m_ovf = e.ovf; m_ready = 1'b1;
        hold(k);
        if (scramble) begin
            eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom); baud = 4'($urandom);
        end
        for (int i = 0; i < nd; i++) begin
            rx = dd[i];
            if (i == spike_bit) begin
                hold(h - 1);
                rx = 1'b1;
                hold(1);
                rx = dd[i];
                hold(k - h);
            end else begin
                hold(k);
            end
        end
        if (p_en) begin
            rx = (^dd) ^ odd ^ par_flip;
            hold(k);
        end
        rx = !stop_low;
        hold(2 + h);
        if (strobe_done) begin
            read_strobe = 1'b1;
            hold(1);
            read_strobe = 1'b0;
            hold(k - h - 3);
        end else begin
            hold(k - h - 2);
        end
        rx = 1'b1;
    endtask

    task automatic do_read(input string tag);
        read_strobe = 1'b1;
        hold(1);
        read_strobe = 1'b0;
        m_ready = 1'b0;
        m_ovf   = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        cyc = 0; n_pass = 0; n_total = 0; ready_prev_s = 1'b0;
        rst_n = 1'b0; rx = 1'b1; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        baud = 4'd11; read_strobe = 1'b0;
        m_data = 8'h00; m_ready = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        hold(5);
        check_outputs("reset");
        rst_n = 1'b1;
        hold(10);

        // 8N1 at the fastest rate: exact ready latency, then acknowledge.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        hold(5);
        do_read("read_a5");
        do_read("read_idle_noeffect");

        // 7E1 with bad then good parity.
        send_frame(8'h41, 1'b0, 1'b1, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        hold(3);
        do_read("read_7e1_bad");
        send_frame(8'h41, 1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        hold(3);
        do_read("read_7e1_good");

        // Low stop bit flags a framing error.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        hold(3);
        do_read("read_ferr");

        // Overrun, then the same pair with an acknowledge in the completion cycle.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        hold(3);
        do_read("read_ovf");
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        hold(3);
        check_outputs("strobe_in_done");
        do_read("read_after_strobe_done");

        // Short low glitch must be rejected without touching outputs.
        send_frame(8'h96, 1'b1, 1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        hold(3);
        rx = 1'b0;
        hold(10);
        rx = 1'b1;
        hold(150);
        check_outputs("glitch");
        do_read("read_before_glitch2");

`ifdef UART_RX_MAJORITY_EN
        // One-clock high spike at the sample point of a zero bit is voted out.
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        hold(3);
        do_read("read_spike");
`endif

        // Reset during bit 4 aborts the frame; the next frame is clean.
        eight = 1'b1; pen = 1'b0; baud = 4'd11;
        hold(1);
        rx = 1'b0;
        hold(54);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(i & 1);
            hold(54);
        end
        rx = 1'b0;
        hold(20);
        rst_n = 1'b0;
        rx = 1'b1;
        hold(3);
        m_data = 8'h00; m_ready = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        check_outputs("mid_frame_reset");
        rst_n = 1'b1;
        hold(300);
        check_outputs("after_reset_idle");
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        hold(3);
        do_read("read_5a");

        // Randomized frames with config scrambled mid-frame and random acknowledges.
        for (int n = 0; n < 16; n++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       4'($urandom_range(10, 15)), 1'($urandom),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                       1'b1, -1);
            hold($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) do_read("read_random");
        end

        for (int i = 0; i < 5000 && q.size() > 0; i++) hold(1);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
